fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC register and the IF/ID pipeline register. It consumes PCWrite/IF_ID_Write

---
 rtl/riscv_pipe_pkg.sv | 6 +
 rtl/if_id_pipe_reg.sv | 37 +++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline constants and fetch FSM state type
package riscv_pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} fetch_state_t;
endpackage

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID register with flush > hold > load > bubble priority
module if_id_pipe_reg #(
    parameter int XLEN = riscv_pipe_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            write_en,
    input  logic            load,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_plus4_f,
    input  logic [31:0]     instr_f,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic [31:0]     instr_d,
    output logic            valid_d
);
    import riscv_pipe_pkg::*;

    // Bubbles keep pc_d/pc_plus4_d so Decode still sees the last real PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_d       <= '0;
            pc_plus4_d <= '0;
            instr_d    <= NOP_INSTR;
            valid_d    <= 1'b0;
        end else if (flush || (write_en && !load)) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (write_en) begin
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            instr_d    <= instr_f;
            valid_d    <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, fetch FSM and IF/ID register feeding Decode
// Optional FETCH_PERF_EN adds saturating stall/flush performance counters.
module fetch_stage #(
    parameter int               XLEN     = riscv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic [31:0]     instr_d,
    output logic            valid_d,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    output logic            fetch_busy
);
    import riscv_pipe_pkg::*;

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc_f, pc_plus4_f;
    logic            fire;

    assign pc_plus4_f = pc_f + XLEN'(4);
    assign fire       = imem_ready && state != S_BOOT;
    assign imem_addr  = pc_f;

    // A redirect abandons any outstanding miss and restarts fetching at the target.
    always_comb state_n = (pc_src_e || imem_ready || state == S_BOOT) ? S_FETCH : S_WAIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BOOT;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            pc_f       <= RESET_PC;
        end else begin
            state      <= state_n;
            imem_req   <= state_n != S_BOOT;
            fetch_busy <= state_n == S_WAIT;
            pc_f       <= pc_src_e ? {pc_target_e[XLEN-1:2], 2'b00} :
                          (pc_write && fire) ? pc_plus4_f : pc_f;
        end
    end

    if_id_pipe_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (pc_src_e),
        .write_en   (if_id_write),
        .load       (fire),
        .pc_f       (pc_f),
        .pc_plus4_f (pc_plus4_f),
        .instr_f    (imem_rdata),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .instr_d    (instr_d),
        .valid_d    (valid_d)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + 32'((state == S_WAIT || !pc_write) && perf_stall_cnt != '1);
            perf_flush_cnt <= perf_flush_cnt + 32'(pc_src_e && perf_flush_cnt != '1);
        end
    end
`endif

    // Advancing the PC while IF/ID holds drops the fetched word.
    a_no_lost_word: assert property (@(posedge clk) disable iff (rst)
        !(pc_write && !if_id_write && !pc_src_e))
        else $error("fetch_stage: pc_write=1 with if_id_write=0 drops a fetched word");
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        if_id_write = 1'b1;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] pc_d, pc_plus4_d, instr_d;
    logic        valid_d, fetch_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
    int checks = 0;
    int failures = 0;
    logic [128:0] obs, exp_v;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;
    assign obs = {imem_addr, pc_d, pc_plus4_d, instr_d, valid_d};

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .instr_d     (instr_d),
        .valid_d     (valid_d),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .fetch_busy  (fetch_busy)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({imem_req, fetch_busy, obs} !== {2'b00, 32'h0, 32'h0, 32'h0, NOP, 1'b0}) begin
            failures++;
            $display("FAIL reset: got req=%b busy=%b %h", imem_req, fetch_busy, obs);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({imem_req, obs} !== {1'b1, 32'h0, 32'h0, 32'h0, NOP, 1'b0}) begin
            failures++;
            $display("FAIL boot: got req=%b %h", imem_req, obs);
        end
    endtask

    task automatic test_pipeline();
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_v = {32'(4 * i), 32'(4 * (i - 1)), 32'(4 * i), tag(32'(4 * (i - 1))), 1'b1};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL pipeline[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_hazard_hold();
        pc_write = 1'b0;
        if_id_write = 1'b0;
        tick();
        exp_v = {32'h10, 32'h0C, 32'h10, tag(32'h0C), 1'b1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL hold: got %h expected %h", obs, exp_v);
        end
        pc_write = 1'b1;
        if_id_write = 1'b1;
        for (int a = 'h14; a <= 'h20; a += 4) begin
            tick();
            exp_v = {32'(a), 32'(a - 4), 32'(a), tag(32'(a - 4)), 1'b1};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL resume@%h: got %h expected %h", a, obs, exp_v);
            end
        end
    endtask

    task automatic test_miss();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {32'h20, 32'h1C, 32'h20, NOP, 1'b0};
            checks++;
            if ({fetch_busy, obs} !== {1'b1, exp_v}) begin
                failures++;
                $display("FAIL miss[%0d]: got busy=%b %h expected busy=1 %h", i, fetch_busy, obs, exp_v);
            end
        end
        imem_ready = 1'b1;
        tick();
        exp_v = {32'h24, 32'h20, 32'h24, tag(32'h20), 1'b1};
        checks++;
        if ({fetch_busy, obs} !== {1'b0, exp_v}) begin
            failures++;
            $display("FAIL miss_done: got busy=%b %h expected busy=0 %h", fetch_busy, obs, exp_v);
        end
    endtask

    task automatic test_redirect();
        pc_write = 1'b0;
        pc_src_e = 1'b1;
        pc_target_e = 32'h103;
        tick();
        exp_v = {32'h100, 32'h20, 32'h24, NOP, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL redirect: got %h expected %h", obs, exp_v);
        end
        pc_write = 1'b1;
        pc_src_e = 1'b0;
        tick();
        exp_v = {32'h104, 32'h100, 32'h104, tag(32'h100), 1'b1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL redirect_fetch: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_wrap();
        pc_src_e = 1'b1;
        pc_target_e = 32'hFFFF_FFFF;
        tick();
        exp_v = {32'hFFFF_FFFC, 32'h100, 32'h104, NOP, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL wrap_target: got %h expected %h", obs, exp_v);
        end
        pc_src_e = 1'b0;
        tick();
        exp_v = {32'h0, 32'hFFFF_FFFC, 32'h0, tag(32'hFFFF_FFFC), 1'b1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL wrap: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_in_wait();
        imem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (fetch_busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_entry: busy=%b expected 1", fetch_busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({imem_req, fetch_busy, imem_addr, valid_d} !== {2'b00, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL rst_in_wait: req=%b busy=%b addr=%h valid=%b expected 0 0 0 0",
                     imem_req, fetch_busy, imem_addr, valid_d);
        end
        rst = 1'b0;
        imem_ready = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr, valid_d} !== {1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL rst_in_wait_boot: req=%b addr=%h valid=%b expected 1 0 0",
                     imem_req, imem_addr, valid_d);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        checks++;
        if ({perf_stall_cnt, perf_flush_cnt} !== 64'h0) begin
            failures++;
            $display("FAIL perf_reset: stall=%0d flush=%0d expected 0 0", perf_stall_cnt, perf_flush_cnt);
        end
        rst = 1'b0;
        tick();
        imem_ready = 1'b0;
        repeat (3) tick();
        imem_ready = 1'b1;
        tick();
        pc_write = 1'b0;
        repeat (2) tick();
        pc_write = 1'b1;
        pc_src_e = 1'b1;
        pc_target_e = 32'h40;
        tick();
        pc_src_e = 1'b0;
        checks++;
        if ({perf_stall_cnt, perf_flush_cnt} !== {32'd5, 32'd1}) begin
            failures++;
            $display("FAIL perf_count: stall=%0d flush=%0d expected 5 1", perf_stall_cnt, perf_flush_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({perf_stall_cnt, perf_flush_cnt} !== 64'h0) begin
            failures++;
            $display("FAIL perf_clear: stall=%0d flush=%0d expected 0 0", perf_stall_cnt, perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pipeline();
        test_hazard_hold();
        test_miss();
        test_redirect();
        test_wrap();
        test_reset_in_wait();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
